// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial owner of the RAM/IO port, arbitrating instruction fetch against the load-store buffer.
//   clk_in, rst_in (sync, active-high), rdy_in (0 freezes), rob_clear (flush)
//   mem_din/mem_dout/mem_a/mem_wr: byte-wide RAM/IO bus; io_buffer_full stalls IO writes
//   if_req/if_addr -> if_done/if_data: 32-bit instruction fetch
//   lsb_req/lsb_store/lsb_addr/lsb_data/lsb_op -> lsb_done/lsb_res: loads and stores
//   mem_stuck: high whenever a transaction is in flight
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_req,
    input  logic        lsb_store,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_data,
    input  logic [2:0]  lsb_op,
    output logic        lsb_done,
    output logic [31:0] lsb_res,
    output logic        mem_stuck
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;
    state_t      r_state, w_next;
    logic [2:0]  r_cnt, r_n, r_op, w_n;
    logic [31:0] r_addr, r_data, r_buf, w_a;
    logic        r_lsb, r_last_lsb, r_store, r_flushed;
    logic        w_grant_lsb, w_accept, w_stall;

    assign w_grant_lsb = lsb_req && (!if_req || !r_last_lsb);
    assign w_accept    = (r_state == S_IDLE) && (if_req || lsb_req) && !rob_clear && rdy_in;
    assign w_n         = !w_grant_lsb ? 3'd4 : lsb_op[1:0] == 2'd0 ? 3'd1 : lsb_op[1:0] == 2'd1 ? 3'd2 : 3'd4;
    assign w_a         = r_addr + {29'd0, r_cnt};
    assign w_stall     = (w_a[17:16] == 2'b11) && io_buffer_full;

    always_comb begin
        w_next   = r_state;
        mem_a    = 32'd0;
        mem_dout = 8'd0;
        mem_wr   = 1'b0;
        case (r_state)
            S_IDLE: w_next = w_accept ? ((w_grant_lsb && lsb_store) ? S_WR : S_RD) : S_IDLE;
            S_RD: begin
                // While frozen, re-present the previous byte address so mem_din still holds it on resume
                mem_a  = (!rdy_in && r_cnt != 3'd0) ? w_a - 32'd1 : (r_cnt < r_n ? w_a : 32'd0);
                w_next = rob_clear ? S_IDLE : (r_cnt == r_n ? S_DONE : S_RD);
            end
            S_WR: begin
                mem_a    = w_a;
                mem_dout = 8'(r_data >> {r_cnt[1:0], 3'b000});
                mem_wr   = rdy_in && !w_stall;
                w_next   = (mem_wr && r_cnt == r_n - 3'd1) ? S_DONE : S_WR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_n        <= 3'd0;
            r_op       <= 3'd0;
            r_addr     <= 32'd0;
            r_data     <= 32'd0;
            r_buf      <= 32'd0;
            r_lsb      <= 1'b0;
            r_last_lsb <= 1'b1;
            r_store    <= 1'b0;
            r_flushed  <= 1'b0;
        end else if (rdy_in) begin
            r_state <= w_next;
            if (w_accept) begin
                r_lsb      <= w_grant_lsb;
                r_last_lsb <= w_grant_lsb;
                r_addr     <= w_grant_lsb ? lsb_addr : if_addr;
                r_data     <= lsb_data;
                r_op       <= lsb_op;
                r_store    <= w_grant_lsb && lsb_store;
                r_n        <= w_n;
                r_cnt      <= 3'd0;
                r_buf      <= 32'd0;
                r_flushed  <= 1'b0;
            end
            if (r_state == S_RD) begin
                r_cnt <= r_cnt + 3'd1;
                // mem_din carries the byte requested one cycle earlier
                if (r_cnt != 3'd0)
                    r_buf <= r_buf | ({24'd0, mem_din} << {r_cnt - 3'd1, 3'b000});
            end
            if (r_state == S_WR && mem_wr)
                r_cnt <= r_cnt + 3'd1;
            // A flushed store still drains every byte; only its completion pulse is dropped
            if (r_state == S_WR && rob_clear)
                r_flushed <= 1'b1;
        end
    end

    assign if_done   = (r_state == S_DONE) && rdy_in && !rob_clear && !r_lsb;
    assign lsb_done  = (r_state == S_DONE) && rdy_in && !rob_clear && r_lsb && !r_flushed;
    assign if_data   = r_buf;
    assign lsb_res   = r_store ? 32'd0 :
                       r_op[1:0] == 2'd0 ? {{24{r_buf[7] & ~r_op[2]}}, r_buf[7:0]} :
                       r_op[1:0] == 2'd1 ? {{16{r_buf[15] & ~r_op[2]}}, r_buf[15:0]} : r_buf;
    assign mem_stuck = (r_state != S_IDLE);
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checks of mem_ctrl against a byte-array memory model.
module tb_mem_ctrl;
    logic        clk_in = 1'b0, rst_in, rdy_in, rob_clear, io_buffer_full;
    logic        if_req, lsb_req, lsb_store, mem_wr, if_done, lsb_done, mem_stuck;
    logic [7:0]  mem_din = 8'd0, mem_dout, nxt_din = 8'd0;
    logic [31:0] mem_a, if_addr, if_data, lsb_addr, lsb_data, lsb_res;
    logic [2:0]  lsb_op;
    logic [7:0]  ram [int unsigned];
    logic [7:0]  mdl [int unsigned];
    int          checks = 0, errors = 0, cyc = 0;
    int          lat, ws, wb, sa, n, rv;
    logic [31:0] res, a, d, expv, g;
    logic [2:0]  op;
    logic        st, rf, rl;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_data(if_data), .lsb_req(lsb_req), .lsb_store(lsb_store),
        .lsb_addr(lsb_addr), .lsb_data(lsb_data), .lsb_op(lsb_op), .lsb_done(lsb_done),
        .lsb_res(lsb_res), .mem_stuck(mem_stuck)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) mem_din <= nxt_din;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nedge();
        @(negedge clk_in);
        cyc++;
    endtask

    // Memory: writes land at this edge, read data appears after it
    task automatic settle();
        #1;
        if (mem_wr === 1'b1) ram[mem_a] = mem_dout;
        nxt_din = ram.exists(mem_a) ? ram[mem_a] : 8'h00;
    endtask

    function automatic logic [31:0] rd_model(input logic [31:0] ad, input logic [2:0] o);
        int     nb;
        longint v;
        nb = (o[1:0] == 2'd0) ? 1 : (o[1:0] == 2'd1) ? 2 : 4;
        v = 0;
        for (int i = 0; i < nb; i++) v += longint'(mdl[ad + 32'(i)]) << (8 * i);
        if (!o[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
        return v[31:0];
    endfunction

    task automatic lsb_txn(input logic s, input logic [31:0] ad, input logic [31:0] dt, input logic [2:0] o,
                           input int rdy_pct, input int full_n, input int rob_at, input int max_c,
                           output int l, output logic [31:0] r, output int w_seen, output int w_bad,
                           output int stuck_after);
        int t0;
        nedge();
        lsb_req = 1'b1; lsb_store = s; lsb_addr = ad; lsb_data = dt; lsb_op = o;
        settle();
        t0 = cyc; l = -1; r = 32'hxxxxxxxx; w_seen = 0; w_bad = 0; stuck_after = -1;
        for (int k = 1; k <= max_c && l < 0; k++) begin
            nedge();
            rdy_in = ($urandom_range(99) >= 32'(rdy_pct));
            io_buffer_full = (k <= full_n);
            rob_clear = (k == rob_at);
            if (k == rob_at) lsb_req = 1'b0;
            settle();
            if (mem_wr) begin
                w_seen++;
                if (io_buffer_full || !rdy_in) w_bad++;
            end
            if (k == rob_at + 1) stuck_after = 32'(mem_stuck);
            if (lsb_done) begin
                l = cyc - t0;
                r = lsb_res;
                lsb_req = 1'b0;
            end
        end
        rdy_in = 1'b1; io_buffer_full = 1'b0; rob_clear = 1'b0; lsb_req = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'd0; lsb_req = 1'b0; lsb_store = 1'b0;
        lsb_addr = 32'd0; lsb_data = 32'd0; lsb_op = 3'd0;
        ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
        ram[32'h200] = 8'h80; ram[32'h202] = 8'hFE; ram[32'h203] = 8'hFF;
        for (int i = 0; i < 64; i++) begin
            rv = int'($urandom_range(255));
            ram[32'h1000 + 32'(i)] = 8'(rv);
            mdl[32'h1000 + 32'(i)] = 8'(rv);
        end
        nedge(); nedge(); settle();
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_flags", {27'd0, mem_wr, if_done, lsb_done, mem_stuck, mem_dout != 8'd0}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_lsb_res", lsb_res, 32'd0);

        // Both requesters from reset: fetch first, then strict alternation
        nedge();
        rst_in = 1'b0; if_req = 1'b1; if_addr = 32'h100;
        lsb_req = 1'b1; lsb_store = 1'b0; lsb_addr = 32'h200; lsb_op = 3'd4;
        settle();
        n = 0; rf = 1'b0; rl = 1'b0;
        for (int k = 0; k < 100 && n < 4; k++) begin
            nedge();
            if (rf) if_req = 1'b1;
            if (rl) lsb_req = 1'b1;
            rf = 1'b0; rl = 1'b0;
            settle();
            if (if_done || lsb_done) begin
                g = {30'd0, if_done, lsb_done};
                chk($sformatf("arb_order%0d", n), g, (n % 2 == 1) ? 32'd1 : 32'd2);
                if (if_done) begin
                    chk("arb_if_data", if_data, 32'h44332211);
                    if_req = 1'b0; rf = 1'b1;
                end
                if (lsb_done) begin
                    chk("arb_lbu", lsb_res, 32'h00000080);
                    lsb_req = 1'b0; rl = 1'b1;
                end
                n++;
            end
        end
        chk("arb_count", 32'(n), 32'd4);
        nedge(); if_req = 1'b0; lsb_req = 1'b0; settle();
        nedge(); settle();
        chk("arb_idle", {31'd0, mem_stuck}, 32'd0);

        lsb_txn(1'b0, 32'h100, 32'd0, 3'd2, 0, 0, 0, 20, lat, res, ws, wb, sa);
        chk("lw_lat", 32'(lat), 32'd6);
        chk("lw_res", res, 32'h44332211);
        chk("lw_nowr", 32'(ws), 32'd0);
        lsb_txn(1'b0, 32'h200, 32'd0, 3'd0, 0, 0, 0, 20, lat, res, ws, wb, sa);
        chk("lb_lat", 32'(lat), 32'd3);
        chk("lb_res", res, 32'hFFFFFF80);
        lsb_txn(1'b0, 32'h200, 32'd0, 3'd4, 0, 0, 0, 20, lat, res, ws, wb, sa);
        chk("lbu_res", res, 32'h00000080);
        lsb_txn(1'b0, 32'h202, 32'd0, 3'd1, 0, 0, 0, 20, lat, res, ws, wb, sa);
        chk("lh_lat", 32'(lat), 32'd4);
        chk("lh_res", res, 32'hFFFFFFFE);

        lsb_txn(1'b1, 32'h300, 32'hDEADBEEF, 3'd2, 0, 0, 0, 20, lat, res, ws, wb, sa);
        chk("sw_lat", 32'(lat), 32'd5);
        chk("sw_writes", 32'(ws), 32'd4);
        chk("sw_res", res, 32'd0);
        chk("sw_mem", {ram[32'h303], ram[32'h302], ram[32'h301], ram[32'h300]}, 32'hDEADBEEF);

        lsb_txn(1'b1, 32'h30000, 32'h41, 3'd0, 0, 3, 0, 20, lat, res, ws, wb, sa);
        chk("sb_io_lat", 32'(lat), 32'd5);
        chk("sb_io_writes", 32'(ws), 32'd1);
        chk("sb_io_wr_full", 32'(wb), 32'd0);
        chk("sb_io_mem", {24'd0, ram[32'h30000]}, 32'h41);

        lsb_txn(1'b0, 32'h100, 32'd0, 3'd2, 0, 0, 2, 12, lat, res, ws, wb, sa);
        chk("flush_rd_done", 32'(lat), 32'hFFFFFFFF);
        chk("flush_rd_idle", 32'(sa), 32'd0);
        lsb_txn(1'b1, 32'h400, 32'hA1B2C3D4, 3'd2, 0, 0, 2, 12, lat, res, ws, wb, sa);
        chk("flush_wr_done", 32'(lat), 32'hFFFFFFFF);
        chk("flush_wr_writes", 32'(ws), 32'd4);
        chk("flush_wr_mem", {ram[32'h403], ram[32'h402], ram[32'h401], ram[32'h400]}, 32'hA1B2C3D4);

        // Random loads/stores with random rdy_in freezes, scored against the byte model
        for (int i = 0; i < 40; i++) begin
            st = 1'($urandom_range(1));
            a = 32'h1000 + $urandom_range(60);
            d = $urandom;
            rv = int'($urandom_range(st ? 2 : 4));
            op = 3'((rv > 2) ? rv + 1 : rv);
            expv = rd_model(a, op);
            lsb_txn(st, a, d, op, 20, 0, 0, 200, lat, res, ws, wb, sa);
            chk("rnd_done", {31'd0, lat > 0}, 32'd1);
            chk("rnd_badwr", 32'(wb), 32'd0);
            if (st) begin
                for (int j = 0; j < ((op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4); j++)
                    mdl[a + 32'(j)] = 8'(d >> (8 * j));
                chk("rnd_sres", res, 32'd0);
            end else
                chk("rnd_lres", res, expv);
        end
        for (int i = 0; i < 64; i++)
            chk($sformatf("rnd_ram%0d", i), {24'd0, ram[32'h1000 + 32'(i)]}, {24'd0, mdl[32'h1000 + 32'(i)]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
